pipeline_ctrl: RTL

- Consumer end of the hazard_op interface driven by the hazard detection unit in the 5-stage RV32I forward pipeline.
- Decodes the 6-bit hazard_op into the following controls:
  - PC and pipeline-register enables;
  - flush (bubble) controls;
  - EX-stage operand-A/B forwarding mux selects.
- Enforces bounded stalls with a small FSM and keeps saturating stall/flush performance counters.
- Sits between hazard detection and the IF/ID, ID/EX and EX/MEM pipeline registers.

---
 rtl/pipe_pkg.sv | 47 ++++
 rtl/sat_counter.sv | 36 +++
 rtl/pipeline_ctrl.sv | 128 ++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// pipe_pkg : shared types and hazard_op encodings for pipeline_ctrl
// Rev 1.0  : initial release
// ============================================================================
package pipe_pkg;

  typedef enum logic [1:0] {
    ALU_MEM = 2'd0,
    ALU_WB  = 2'd1,
    LD_MEM  = 2'd2,
    LD_WB   = 2'd3
  } fwd_src_e;

  typedef enum logic [1:0] {
    REGFILE = 2'd0,
    MEM_ALU = 2'd1,
    WB_ALU  = 2'd2,
    WB_LD   = 2'd3
  } fwd_sel_e;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LU_STALL = 2'd1,
    ST_RF_STALL = 2'd2,
    ST_FLUSH    = 2'd3
  } ctrl_state_e;

  localparam logic [5:0] HOP_BRANCH = 6'b001111;
  localparam logic [5:0] HOP_RFWAIT = 6'b000111;

  // A load source only reaches the mux once it sits in WB, so LD_MEM maps to WB_LD.
  function automatic fwd_sel_e src_to_sel(input logic valid, input fwd_src_e src);
    fwd_sel_e sel;
    sel = REGFILE;
    if (valid) begin
      case (src)
        ALU_MEM: sel = MEM_ALU;
        ALU_WB:  sel = WB_ALU;
        default: sel = WB_LD;
      endcase
    end
    return sel;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// sat_counter : W-bit incrementer that sticks at all-ones
// Rev 1.0     : initial release
// ============================================================================
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule
`default_nettype wire

// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// pipeline_ctrl : decodes hazard_op into enables, flushes and forward selects
// Rev 1.0       : initial release
// ============================================================================
module pipeline_ctrl
  import pipe_pkg::*;
#(
  parameter int CNT_W     = 16,
  parameter int MAX_STALL = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [5:0]       hazard_op_i,
  output logic             pc_en_o,
  output logic             if_id_en_o,
  output logic             id_ex_en_o,
  output logic             if_id_flush_o,
  output logic             id_ex_flush_o,
  output logic             ex_mem_flush_o,
  output logic [1:0]       fwd_a_sel_o,
  output logic [1:0]       fwd_b_sel_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic             stall_err_o
);

  localparam int              WD_W     = $clog2(MAX_STALL + 1);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(MAX_STALL);

  ctrl_state_e     state_q, state_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic            err_q, err_d;
  logic            req_branch, req_rfwait, req_loaduse;
  logic            force_run, stall, flush_inc;
  fwd_sel_e        sel_a, sel_b;

  always_comb begin
    req_branch  = (hazard_op_i == HOP_BRANCH);
    req_rfwait  = (hazard_op_i == HOP_RFWAIT);
    req_loaduse = (hazard_op_i[4] && (hazard_op_i[1:0] == 2'd2)) ||
                  (hazard_op_i[5] && (hazard_op_i[3:2] == 2'd2));
    force_run   = (wd_q >= WD_LIMIT);
    sel_a       = src_to_sel(hazard_op_i[4], fwd_src_e'(hazard_op_i[1:0]));
    sel_b       = src_to_sel(hazard_op_i[5], fwd_src_e'(hazard_op_i[3:2]));

    pc_en_o        = 1'b1;
    if_id_en_o     = 1'b1;
    id_ex_en_o     = 1'b1;
    if_id_flush_o  = 1'b0;
    id_ex_flush_o  = 1'b0;
    ex_mem_flush_o = 1'b0;
    fwd_a_sel_o    = sel_a;
    fwd_b_sel_o    = sel_b;
    state_d        = ST_RUN;
    stall          = 1'b0;
    flush_inc      = 1'b0;

    if (rst_i) begin
      pc_en_o        = 1'b0;
      if_id_en_o     = 1'b0;
      id_ex_en_o     = 1'b0;
      if_id_flush_o  = 1'b1;
      id_ex_flush_o  = 1'b1;
      ex_mem_flush_o = 1'b1;
      fwd_a_sel_o    = 2'd0;
      fwd_b_sel_o    = 2'd0;
    end else if (force_run) begin
      // Watchdog release: one plain RUN cycle regardless of the request.
      state_d = ST_RUN;
    end else if (state_q == ST_FLUSH) begin
      if_id_flush_o = 1'b1;
      fwd_a_sel_o   = 2'd0;
      fwd_b_sel_o   = 2'd0;
    end else if (req_branch) begin
      if_id_flush_o = 1'b1;
      id_ex_flush_o = 1'b1;
      flush_inc     = 1'b1;
      state_d       = ST_FLUSH;
    end else if (req_rfwait) begin
      pc_en_o    = 1'b0;
      if_id_en_o = 1'b0;
      id_ex_en_o = 1'b0;
      stall      = 1'b1;
      state_d    = ST_RF_STALL;
    end else if (req_loaduse && (state_q != ST_LU_STALL)) begin
      pc_en_o        = 1'b0;
      if_id_en_o     = 1'b0;
      id_ex_en_o     = 1'b0;
      ex_mem_flush_o = 1'b1;
      stall          = 1'b1;
      state_d        = ST_LU_STALL;
    end

    wd_d  = stall ? (wd_q + WD_W'(1)) : '0;
    err_d = err_q || (wd_d == WD_LIMIT);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_RUN;
      wd_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
      err_q   <= err_d;
    end
  end

  assign stall_err_o = err_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (stall),
    .cnt_o (stall_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (flush_inc),
    .cnt_o (flush_cnt_o)
  );

endmodule
`default_nettype wire
